stall_control_unit: RTL and testbench

Parametrised pipeline stall controller for the MIPS datapath, sitting between instruction decode and the PC/program-memory stage. It decodes the fetched opcode and raises stall for halt, load-use and jump hazards. Stall length per cause is configurable, halt can be made sticky with an explicit resume, and a flush input cancels a stall in progress. Outputs are the stall cause, a halted flag, the registered program-memory stall (stall_pm) and a saturating stall-cycle counter.

---
 rtl/stall_control_unit.sv | 136 +++++++++++++
 tb/tb_stall_control_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/stall_control_unit.sv
// Pipeline stall controller: decodes halt/load/jump opcodes, sequences the
// stall length per cause, and reports cause, halted flag and stall statistics.
module stall_control_unit #(
    parameter int              OP_W        = 6,
    parameter logic [OP_W-1:0] HLT_OP      = 6'b010001,
    parameter logic [OP_W-1:0] LD_OP       = 6'b010100,
    parameter logic [OP_W-1:0] JMP_MASK    = 6'b111100,
    parameter logic [OP_W-1:0] JMP_MATCH   = 6'b011100,
    parameter int              LD_CYC      = 1,
    parameter int              JMP_CYC     = 2,
    parameter bit              HALT_STICKY = 1'b1,
    parameter int              CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OP_W-1:0]  op,
    input  logic             resume,
    input  logic             flush,
    output logic             stall,
    output logic             stall_pm,
    output logic [1:0]       stall_cause,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        LD_WAIT  = 2'b01,
        JMP_WAIT = 2'b10,
        HALTED   = 2'b11
    } state_t;

    localparam logic [3:0]       LD_CYC4  = 4'(LD_CYC);
    localparam logic [3:0]       JMP_CYC4 = 4'(JMP_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       rel_q, rel_nxt;
    logic       is_hlt, is_jmp, is_ld;

    assign is_hlt = (op == HLT_OP);
    assign is_jmp = ((op & JMP_MASK) == JMP_MATCH);
    assign is_ld  = (op == LD_OP);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            rel_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            rel_q <= rel_nxt;
        end
    end

    // Decode and stall sequencing; rel_q gives the held instruction one free cycle.
    always_comb begin
        stall       = 1'b0;
        stall_cause = 2'b00;
        halted      = 1'b0;
        state_nxt   = state;
        cnt_nxt     = cnt;
        rel_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (!rel_q) begin
                    if (is_hlt) begin
                        stall       = 1'b1;
                        stall_cause = 2'b11;
                        halted      = 1'b1;
                        if (HALT_STICKY)
                            state_nxt = HALTED;
                    end else if (!flush && is_jmp) begin
                        stall       = 1'b1;
                        stall_cause = 2'b10;
                        if (JMP_CYC > 1) begin
                            state_nxt = JMP_WAIT;
                            cnt_nxt   = JMP_CYC4 - 4'd1;
                        end else begin
                            rel_nxt = 1'b1;
                        end
                    end else if (!flush && is_ld) begin
                        stall       = 1'b1;
                        stall_cause = 2'b01;
                        if (LD_CYC > 1) begin
                            state_nxt = LD_WAIT;
                            cnt_nxt   = LD_CYC4 - 4'd1;
                        end else begin
                            rel_nxt = 1'b1;
                        end
                    end
                end
            end
            LD_WAIT, JMP_WAIT: begin
                if (flush) begin
                    state_nxt = IDLE;
                    rel_nxt   = 1'b1;
                end else begin
                    stall       = 1'b1;
                    stall_cause = (state == LD_WAIT) ? 2'b01 : 2'b10;
                    if (cnt <= 4'd1) begin
                        state_nxt = IDLE;
                        rel_nxt   = 1'b1;
                    end else begin
                        cnt_nxt = cnt - 4'd1;
                    end
                end
            end
            HALTED: begin
                stall       = 1'b1;
                stall_cause = 2'b11;
                halted      = 1'b1;
                if (resume) begin
                    state_nxt = IDLE;
                    rel_nxt   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered stall for program memory plus saturating stall-cycle counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_pm    <= 1'b0;
            stall_count <= '0;
        end else begin
            stall_pm <= stall;
            if (stall && (stall_count != CNT_MAX))
                stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_stall_control_unit.sv
// Directed bench for stall_control_unit: a default-parameter instance (a) and a
// JMP_CYC=3, non-sticky halt, 4-bit counter instance (b) share the same inputs.
module tb_stall_control_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  op = '0;
    logic        resume = 1'b0;
    logic        flush = 1'b0;

    logic        a_stall, a_pm, a_halted;
    logic [1:0]  a_cause;
    logic [15:0] a_cnt;
    logic        b_stall, b_pm, b_halted;
    logic [1:0]  b_cause;
    logic [3:0]  b_cnt;

    int errors = 0;
    int checks = 0;

    localparam logic [5:0] HLT = 6'b010001;
    localparam logic [5:0] LD  = 6'b010100;
    localparam logic [5:0] JMP = 6'b011100;
    localparam logic [5:0] JMP2 = 6'b011111;

    stall_control_unit u_a (
        .clk(clk), .reset(reset), .op(op), .resume(resume), .flush(flush),
        .stall(a_stall), .stall_pm(a_pm), .stall_cause(a_cause),
        .halted(a_halted), .stall_count(a_cnt)
    );

    stall_control_unit #(.JMP_CYC(3), .HALT_STICKY(1'b0), .CNT_W(4)) u_b (
        .clk(clk), .reset(reset), .op(op), .resume(resume), .flush(flush),
        .stall(b_stall), .stall_pm(b_pm), .stall_cause(b_cause),
        .halted(b_halted), .stall_count(b_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks happen 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; op = '0; flush = 1'b0; resume = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #2;
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL rst_a_stall got=%0b exp=0", a_stall); end
        checks++; if (a_cause !== 2'b00) begin errors++; $display("FAIL rst_a_cause got=%0b exp=00", a_cause); end
        checks++; if (a_halted !== 1'b0) begin errors++; $display("FAIL rst_a_halted got=%0b exp=0", a_halted); end
        checks++; if (a_pm !== 1'b0) begin errors++; $display("FAIL rst_a_pm got=%0b exp=0", a_pm); end
        checks++; if (a_cnt !== 16'd0) begin errors++; $display("FAIL rst_a_cnt got=%0d exp=0", a_cnt); end
        checks++; if (b_cnt !== 4'd0) begin errors++; $display("FAIL rst_b_cnt got=%0d exp=0", b_cnt); end
    endtask

    task automatic test_load();
        do_reset();
        op = LD; #2;
        checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL ld_c0_stall got=%0b exp=1", a_stall); end
        checks++; if (a_cause !== 2'b01) begin errors++; $display("FAIL ld_c0_cause got=%0b exp=01", a_cause); end
        tick(); #2;
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL ld_c1_stall got=%0b exp=0", a_stall); end
        checks++; if (a_pm !== 1'b1) begin errors++; $display("FAIL ld_c1_pm got=%0b exp=1", a_pm); end
        checks++; if (a_cnt !== 16'd1) begin errors++; $display("FAIL ld_c1_cnt got=%0d exp=1", a_cnt); end
        tick(); op = '0; #2;
        checks++; if (a_pm !== 1'b0) begin errors++; $display("FAIL ld_c2_pm got=%0b exp=0", a_pm); end
        checks++; if (a_cnt !== 16'd1) begin errors++; $display("FAIL ld_c2_cnt got=%0d exp=1", a_cnt); end
    endtask

    task automatic test_jump();
        logic [3:0] exp_a;
        logic [3:0] exp_b;
        exp_a = 4'b1011;  // cycles 0..3, bit i = cycle i (re-detect in cycle 3)
        exp_b = 4'b0111;
        do_reset();
        op = JMP2;
        for (int i = 0; i < 4; i++) begin
            #2;
            checks++; if (a_stall !== exp_a[i]) begin errors++; $display("FAIL jmp_a_c%0d_stall got=%0b exp=%0b", i, a_stall, exp_a[i]); end
            checks++; if (b_stall !== exp_b[i]) begin errors++; $display("FAIL jmp_b_c%0d_stall got=%0b exp=%0b", i, b_stall, exp_b[i]); end
            if (exp_b[i]) begin
                checks++; if (b_cause !== 2'b10) begin errors++; $display("FAIL jmp_b_c%0d_cause got=%0b exp=10", i, b_cause); end
            end
            tick();
        end
        op = '0; #2;
        checks++; if (a_cnt !== 16'd3) begin errors++; $display("FAIL jmp_a_cnt got=%0d exp=3", a_cnt); end
        checks++; if (b_cnt !== 4'd3) begin errors++; $display("FAIL jmp_b_cnt got=%0d exp=3", b_cnt); end
    endtask

    task automatic test_halt();
        do_reset();
        op = HLT; #2;
        checks++; if (a_stall !== 1'b1 || a_cause !== 2'b11) begin errors++; $display("FAIL hlt_c0_a got=%0b/%0b exp=1/11", a_stall, a_cause); end
        checks++; if (b_stall !== 1'b1 || b_cause !== 2'b11) begin errors++; $display("FAIL hlt_c0_b got=%0b/%0b exp=1/11", b_stall, b_cause); end
        tick(); op = '0;
        for (int i = 1; i < 6; i++) begin
            #2;
            checks++; if (a_stall !== 1'b1 || a_halted !== 1'b1) begin errors++; $display("FAIL hlt_c%0d_a got=%0b/%0b exp=1/1", i, a_stall, a_halted); end
            checks++; if (b_stall !== 1'b0 || b_halted !== 1'b0) begin errors++; $display("FAIL hlt_c%0d_b got=%0b/%0b exp=0/0", i, b_stall, b_halted); end
            tick();
        end
        resume = 1'b1; #2;
        checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL hlt_c6_stall got=%0b exp=1", a_stall); end
        tick(); resume = 1'b0; op = HLT; #2;
        checks++; if (a_stall !== 1'b0 || a_halted !== 1'b0) begin errors++; $display("FAIL hlt_c7_a got=%0b/%0b exp=0/0", a_stall, a_halted); end
        checks++; if (a_cnt !== 16'd7) begin errors++; $display("FAIL hlt_c7_cnt got=%0d exp=7", a_cnt); end
    endtask

    task automatic test_flush();
        do_reset();
        op = JMP; #2;
        checks++; if (b_stall !== 1'b1) begin errors++; $display("FAIL fl_c0_stall got=%0b exp=1", b_stall); end
        tick(); flush = 1'b1; #2;
        checks++; if (b_stall !== 1'b0 || b_cause !== 2'b00) begin errors++; $display("FAIL fl_c1_b got=%0b/%0b exp=0/00", b_stall, b_cause); end
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL fl_c1_a got=%0b exp=0", a_stall); end
        tick(); flush = 1'b0; #2;
        checks++; if (b_stall !== 1'b0) begin errors++; $display("FAIL fl_c2_rel got=%0b exp=0", b_stall); end
        tick(); flush = 1'b1; #2;
        checks++; if (b_stall !== 1'b0) begin errors++; $display("FAIL fl_c3_idle got=%0b exp=0", b_stall); end
        tick(); flush = 1'b0; #2;
        checks++; if (b_stall !== 1'b1) begin errors++; $display("FAIL fl_c4_redet got=%0b exp=1", b_stall); end
        do_reset();
        op = HLT; flush = 1'b1; #2;
        checks++; if (a_stall !== 1'b1 || a_cause !== 2'b11) begin errors++; $display("FAIL fl_hlt got=%0b/%0b exp=1/11", a_stall, a_cause); end
        flush = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        op = JMP;
        tick(); #2;
        checks++; if (b_stall !== 1'b1) begin errors++; $display("FAIL rm_wait got=%0b exp=1", b_stall); end
        reset = 1'b0;
        tick(); reset = 1'b1; op = '0; #2;
        checks++; if (b_pm !== 1'b0 || b_cnt !== 4'd0) begin errors++; $display("FAIL rm_regs got=%0b/%0d exp=0/0", b_pm, b_cnt); end
        checks++; if (b_stall !== 1'b0) begin errors++; $display("FAIL rm_stall got=%0b exp=0", b_stall); end
        op = JMP; #1;
        checks++; if (b_stall !== 1'b1) begin errors++; $display("FAIL rm_idle_det got=%0b exp=1", b_stall); end
    endtask

    task automatic test_saturate();
        do_reset();
        op = HLT;
        for (int i = 0; i < 20; i++) tick();
        #2;
        checks++; if (b_cnt !== 4'd15) begin errors++; $display("FAIL sat_b_cnt got=%0d exp=15", b_cnt); end
        checks++; if (a_cnt !== 16'd20) begin errors++; $display("FAIL sat_a_cnt got=%0d exp=20", a_cnt); end
        op = '0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_jump();
        test_halt();
        test_flush();
        test_reset_mid_stall();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
